// File: rtl/ucie_ctl_sb_pkg.sv
// Shared types and helpers for the UCIe adapter sideband transmit path.
package ucie_ctl_sb_pkg;

  localparam int unsigned SB_MSG_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } sb_tx_state_e;

  // Number of lp_cfg beats needed for one message on an nc-bit bus.
  function automatic int unsigned beats_per_msg(input int unsigned nc, input logic has_data);
    int unsigned per_section;
    per_section = SB_MSG_W / nc;
    return has_data ? (2 * per_section) : per_section;
  endfunction

endpackage

// File: rtl/ucie_ctl_sb_credit_counter.sv
// Saturating PHY sideband credit counter with sticky overflow flag.
module ucie_ctl_sb_credit_counter #(
  parameter int unsigned CRD_MAX = 4,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_overflow
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(CRD_MAX);

  logic dec_ok;

  // A decrement never takes the count below zero.
  assign dec_ok = i_dec && (o_count != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count    <= MAX;
      o_overflow <= 1'b0;
    end else if (i_inc && !dec_ok) begin
      if (o_count == MAX) begin
        o_overflow <= 1'b1;
      end else begin
        o_count <= o_count + WIDTH'(1);
      end
    end else if (dec_ok && !i_inc) begin
      o_count <= o_count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/ucie_ctl_adapter_sb_cfg_tx.sv
// Adapter sideband transmit stage: buffers one message and serializes it onto
// the RDI lp_cfg bus, gated by PHY credits.
module ucie_ctl_adapter_sb_cfg_tx
  import ucie_ctl_sb_pkg::*;
#(
  parameter int unsigned NC      = 32,
  parameter int unsigned CRD_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_msg_valid,
  input  logic                i_msg_has_data,
  input  logic [SB_MSG_W-1:0] i_msg_hdr,
  input  logic [SB_MSG_W-1:0] i_msg_data,
  output logic                o_msg_ready,
  input  logic                i_rdi_pl_cfg_crd,
  output logic                o_rdi_lp_cfg_valid,
  output logic [NC-1:0]       o_rdi_lp_cfg,
  output logic [3:0]          o_crd_count,
  output logic                o_busy,
  output logic                o_crd_overflow
);

  localparam int unsigned BPS   = SB_MSG_W / NC;
  localparam int unsigned CNT_W = $clog2(BPS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BPS);

  if (!(NC == 8 || NC == 16 || NC == 32 || NC == 64)) begin : g_bad_nc
    $error("NC must be 8, 16, 32 or 64");
  end
  if (CRD_MAX < 1 || CRD_MAX > 15) begin : g_bad_crd
    $error("CRD_MAX must be in 1..15");
  end

  sb_tx_state_e          state;
  logic [SB_MSG_W-1:0]   buf_hdr;
  logic [SB_MSG_W-1:0]   buf_data;
  logic                  buf_has_data;
  logic                  buf_full;
  logic [2*SB_MSG_W-1:0] sreg;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  has_data;
  logic                  accept;
  logic                  launch;
  logic                  buf_full_next;

  assign accept        = i_msg_valid & o_msg_ready;
  assign launch        = (state == IDLE) & buf_full & (o_crd_count != 4'd0);
  assign buf_full_next = accept | (buf_full & ~launch);

  ucie_ctl_sb_credit_counter #(
    .CRD_MAX (CRD_MAX),
    .WIDTH   (4)
  ) u_crd (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_inc      (i_rdi_pl_cfg_crd),
    .i_dec      (launch),
    .o_count    (o_crd_count),
    .o_overflow (o_crd_overflow)
  );

  // Single-entry holding buffer; ready is registered from the next fill state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_hdr      <= '0;
      buf_data     <= '0;
      buf_has_data <= 1'b0;
      buf_full     <= 1'b0;
      o_msg_ready  <= 1'b1;
    end else begin
      if (accept) begin
        buf_hdr      <= i_msg_hdr;
        buf_data     <= i_msg_has_data ? i_msg_data : '0;
        buf_has_data <= i_msg_has_data;
      end
      buf_full    <= buf_full_next;
      o_msg_ready <= ~buf_full_next;
    end
  end

  // Serializer: header slices LSB-first, optional data slices, then one idle GAP cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state              <= IDLE;
      sreg               <= '0;
      beat_cnt           <= '0;
      has_data           <= 1'b0;
      o_rdi_lp_cfg_valid <= 1'b0;
      o_rdi_lp_cfg       <= '0;
      o_busy             <= 1'b0;
    end else begin
      o_busy <= buf_full_next | launch | (state == HDR) | (state == DATA);
      case (state)
        IDLE: begin
          if (launch) begin
            sreg               <= {buf_data, buf_hdr} >> NC;
            o_rdi_lp_cfg       <= buf_hdr[NC-1:0];
            o_rdi_lp_cfg_valid <= 1'b1;
            beat_cnt           <= CNT_W'(1);
            has_data           <= buf_has_data;
            state              <= HDR;
          end
        end
        HDR, DATA: begin
          if (beat_cnt == LAST_BEAT) begin
            if (state == HDR && has_data) begin
              o_rdi_lp_cfg <= sreg[NC-1:0];
              sreg         <= sreg >> NC;
              beat_cnt     <= CNT_W'(1);
              state        <= DATA;
            end else begin
              o_rdi_lp_cfg_valid <= 1'b0;
              o_rdi_lp_cfg       <= '0;
              beat_cnt           <= '0;
              state              <= GAP;
            end
          end else begin
            o_rdi_lp_cfg <= sreg[NC-1:0];
            sreg         <= sreg >> NC;
            beat_cnt     <= beat_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucie_ctl_adapter_sb_cfg_tx.sv
// Scoreboard bench for the adapter sideband transmit stage (NC=32, CRD_MAX=4).
module tb_ucie_ctl_adapter_sb_cfg_tx;

  localparam int unsigned NC      = 32;
  localparam int unsigned CRD_MAX = 4;

  typedef struct {
    logic [NC-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          msg_valid;
  logic          msg_has_data;
  logic [63:0]   msg_hdr;
  logic [63:0]   msg_data;
  logic          msg_ready;
  logic          crd;
  logic          lp_valid;
  logic [NC-1:0] lp_cfg;
  logic [3:0]    crd_count;
  logic          busy;
  logic          crd_ovf;

  beat_t       exp_q[$];
  beat_t       mon_b;
  logic        prev_valid = 1'b0;
  logic        prev_last  = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] rh;
  logic [63:0] rd;
  logic [63:0] h6;

  always #5 clk = ~clk;

  ucie_ctl_adapter_sb_cfg_tx #(
    .NC      (NC),
    .CRD_MAX (CRD_MAX)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_msg_valid        (msg_valid),
    .i_msg_has_data     (msg_has_data),
    .i_msg_hdr          (msg_hdr),
    .i_msg_data         (msg_data),
    .o_msg_ready        (msg_ready),
    .i_rdi_pl_cfg_crd   (crd),
    .o_rdi_lp_cfg_valid (lp_valid),
    .o_rdi_lp_cfg       (lp_cfg),
    .o_crd_count        (crd_count),
    .o_busy             (busy),
    .o_crd_overflow     (crd_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops one expected beat per valid cycle, checks framing.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_valid = 1'b0;
      prev_last  = 1'b0;
    end else if (lp_valid) begin
      check("gap_between_msgs", 64'(prev_valid & prev_last), 64'd0);
      if (exp_q.size() == 0) begin
        check("spurious_beat", 64'(lp_valid), 64'd0);
        prev_last = 1'b1;
      end else begin
        mon_b = exp_q.pop_front();
        check("beat_data", 64'(lp_cfg), 64'(mon_b.data));
        prev_last = mon_b.last;
      end
      prev_valid = 1'b1;
    end else begin
      if (prev_valid) check("contiguous_valid", 64'(prev_last), 64'd1);
      prev_valid = 1'b0;
      prev_last  = 1'b0;
    end
  end

  task automatic send(input logic [63:0] h, input logic hd, input logic [63:0] d);
    int          n;
    int          nb;
    logic [127:0] msg;
    beat_t       b;
    n = 0;
    while (!msg_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!msg_ready) check("ready_timeout", 64'(msg_ready), 64'd1);
    msg = {d, h};
    nb  = hd ? 4 : 2;
    for (int i = 0; i < nb; i++) begin
      b.data = msg[i*NC +: NC];
      b.last = (i == nb - 1);
      exp_q.push_back(b);
    end
    msg_valid    = 1'b1;
    msg_has_data = hd;
    msg_hdr      = h;
    msg_data     = d;
    @(posedge clk);
    #1;
    msg_valid    = 1'b0;
    msg_has_data = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic pulse_crd();
    crd = 1'b1;
    @(posedge clk);
    #1;
    crd = 1'b0;
  endtask

  initial begin
    msg_valid    = 1'b0;
    msg_has_data = 1'b0;
    msg_hdr      = '0;
    msg_data     = '0;
    crd          = 1'b0;
    #1 rst = 1'b1;
    #21 rst = 1'b0;
    @(posedge clk);
    #1;

    check("rst_valid", 64'(lp_valid), 64'd0);
    check("rst_lp_cfg", 64'(lp_cfg), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(crd_ovf), 64'd0);
    check("rst_ready", 64'(msg_ready), 64'd1);
    check("rst_crd", 64'(crd_count), 64'(CRD_MAX));

    // Header-only message: two beats, first beat one edge after acceptance.
    send(64'h1122334455667788, 1'b0, 64'h0);
    check("t1_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    check("t1_first_valid", 64'(lp_valid), 64'd1);
    check("t1_beat0", 64'(lp_cfg), 64'h55667788);
    @(posedge clk);
    #1;
    check("t1_beat1", 64'(lp_cfg), 64'h11223344);
    @(posedge clk);
    #1;
    check("t1_gap_valid", 64'(lp_valid), 64'd0);
    check("t1_crd", 64'(crd_count), 64'd3);
    wait_idle();
    pulse_crd();
    check("t1_crd_ret", 64'(crd_count), 64'd4);

    // Header plus data: four contiguous beats.
    send(64'h0123456789ABCDEF, 1'b1, 64'hDEADBEEFCAFEF00D);
    wait_idle();
    check("t2_crd", 64'(crd_count), 64'd3);
    pulse_crd();

    // Return at full count saturates and sets the sticky flag.
    pulse_crd();
    check("ovf_crd", 64'(crd_count), 64'(CRD_MAX));
    check("ovf_flag", 64'(crd_ovf), 64'd1);

    // Exhaust credits: CRD_MAX messages go out, the next one is held.
    for (int i = 0; i < CRD_MAX + 1; i++) begin
      rh = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      send(rh, i[0], rd);
    end
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    check("t3_ready_held", 64'(msg_ready), 64'd0);
    check("t3_crd_zero", 64'(crd_count), 64'd0);
    check("t3_busy_held", 64'(busy), 64'd1);
    check("t3_valid_low", 64'(lp_valid), 64'd0);
    check("t3_pending_beats", 64'(exp_q.size()), 64'd2);
    pulse_crd();
    check("t3_crd_one", 64'(crd_count), 64'd1);
    check("t3_no_launch_yet", 64'(lp_valid), 64'd0);
    @(posedge clk);
    #1;
    check("t3_launch", 64'(lp_valid), 64'd1);
    check("t3_crd_after", 64'(crd_count), 64'd0);
    check("t3_ready_after", 64'(msg_ready), 64'd1);
    wait_idle();

    // Launch and credit return in the same edge at count=1.
    pulse_crd();
    send(64'hFEDCBA9876543210, 1'b0, 64'h0);
    crd = 1'b1;
    @(posedge clk);
    #1;
    crd = 1'b0;
    check("t4_launch", 64'(lp_valid), 64'd1);
    check("t4_crd_same", 64'(crd_count), 64'd1);
    wait_idle();

    // Reset during beat 1 of a four-beat message.
    check("ovf_sticky", 64'(crd_ovf), 64'd1);
    h6 = 64'hA5A5C3C3_0F0F1234;
    send(h6, 1'b1, 64'h99887766_55443322);
    @(posedge clk);
    #1;
    check("t6_beat0", 64'(lp_cfg), 64'h0F0F1234);
    @(posedge clk);
    #1;
    check("t6_beat1", 64'(lp_cfg), 64'hA5A5C3C3);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(lp_valid), 64'd0);
    check("t6_rst_lp_cfg", 64'(lp_cfg), 64'd0);
    check("t6_rst_crd", 64'(crd_count), 64'(CRD_MAX));
    check("t6_rst_ready", 64'(msg_ready), 64'd1);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_overflow", 64'(crd_ovf), 64'd0);
    #2 rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("t6_quiet", 64'(lp_valid), 64'd0);
    check("t6_crd_after", 64'(crd_count), 64'(CRD_MAX));
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ucie_ctl_adapter_sb_cfg_tx.md
Name: ucie_ctl_adapter_sb_cfg_tx

Overview:
- Adapter-side sideband transmit stage. Sits directly upstream of the PHY sideband message interface and drives its RDI lp_cfg inputs.
- Accepts whole sideband messages from adapter logic: a 64-bit header plus an optional 64-bit data payload.
- Holds one message in a buffer, then serializes it onto an NC-bit lp_cfg bus with lp_cfg_valid.
- Sends only while it holds a PHY credit. Credits are returned on pl_cfg_crd.

Parameters:
- NC, 32: lp_cfg beat width. Legal values are 8, 16, 32 and 64; any other value is an elaboration error.
- CRD_MAX, 4: initial and maximum credit count. Legal range is 1 to 15.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_msg_valid  in  1  message offered
- i_msg_has_data  in  1  message carries the 64-bit data payload
- i_msg_hdr  in  64  message header
- i_msg_data  in  64  payload; ignored when has_data=0
- o_msg_ready  out  1  holding buffer empty
- i_rdi_pl_cfg_crd  in  1  single-cycle credit return pulse
- o_rdi_lp_cfg_valid  out  1  beat valid
- o_rdi_lp_cfg  out  NC  beat data
- o_crd_count  out  4  current credits
- o_busy  out  1  serializer not idle, or buffer full
- o_crd_overflow  out  1  sticky: a credit was returned while count=CRD_MAX

Behaviour:
- Reset values:
  - o_rdi_lp_cfg_valid=0, o_rdi_lp_cfg=0, o_busy=0, o_crd_overflow=0.
  - o_msg_ready=1, o_crd_count=CRD_MAX.
  - State=IDLE; buffer and shift register cleared.
- Reset mid-message: the message is dropped immediately, with no further beats and valid low asynchronously. Credits are restored to CRD_MAX.
- Accept:
  - A message is accepted on a rising edge where i_msg_valid=1 and o_msg_ready=1.
  - Header, payload and has_data are captured into the holding buffer.
  - o_msg_ready = !buf_full, a registered signal.
- Launch condition: state=IDLE, buf_full=1, crd_count>0. When it holds, the next edge:
  - moves the buffer into the 128-bit shift register and clears buf_full;
  - decrements credits;
  - enters HDR with beat 0 on the outputs.
- Latency:
  - Acceptance at edge E0 gives first beat valid after edge E0+1, given credit and an idle serializer.
  - The buffer may accept a new message during serialization, but not in the same edge it launches.
- Serialization:
  - Beats go LSB-first: header[NC-1:0] first, then successive NC slices.
  - When has_data=1, the data slices follow the header slices.
  - Beats per section = 64/NC; the beat counter is log2(64/NC)+1 bits wide.
  - o_rdi_lp_cfg_valid stays high continuously from the first beat to the last beat of a message.
- FSM states:
  - IDLE to HDR on the launch condition.
  - HDR to DATA after the last header beat, when has_data=1.
  - HDR to GAP after the last header beat, when has_data=0.
  - DATA to GAP after the last data beat.
  - GAP to IDLE unconditionally.
- GAP guarantees at least one cycle of valid=0 between messages, which the downstream interface needs to return to IDLE. A back-to-back minimum period is therefore beats+2 cycles.
- Outputs are registered. In IDLE and GAP: valid=0 and o_rdi_lp_cfg=0.
- Credits:
  - A pulse on i_rdi_pl_cfg_crd increments the count by 1.
  - Launch and return in the same cycle leaves the count unchanged.
  - A return while count=CRD_MAX saturates the count and sets o_crd_overflow, which clears only on reset.
  - At count=0 the message waits in the buffer, o_msg_ready=0, and valid stays low.
- o_busy = (state!=IDLE) | buf_full.

Decomposition:
- Package ucie_ctl_sb_pkg holds:
  - the state enum sb_tx_state_e {IDLE, HDR, DATA, GAP};
  - the constant SB_MSG_W=64;
  - the function beats_per_msg(nc, has_data).
- One sub-module, ucie_ctl_sb_credit_counter, owns the saturating up/down counter and the overflow flag. It has parameters CRD_MAX and width, and ports i_clk, i_rst, i_inc, i_dec, o_count, o_overflow.
- Serializer FSM and holding buffer stay in the top module.

Test Plan:
1. NC=32: send header 0x1122334455667788 with has_data=0. Expect, starting the edge after E0+1, two valid beats 0x55667788 then 0x11223344. Then valid=0 for at least 1 cycle, credits 4 to 3.
2. NC=32: send header H and data 0xDEADBEEFCAFEF00D with has_data=1. Expect 4 contiguous beats: H[31:0], H[63:32], 0xCAFEF00D, 0xDEADBEEF.
3. CRD_MAX=2: offer 3 messages back-to-back with no returns.
   - Expect 2 transmitted and the third held, with o_msg_ready=0 and o_crd_count=0.
   - A single i_rdi_pl_cfg_crd pulse makes the third launch on the following edge.
4. Assert i_rdi_pl_cfg_crd in the same cycle as a launch with count=1. Expect count stays 1.
5. Pulse i_rdi_pl_cfg_crd at count=CRD_MAX. Expect count to remain CRD_MAX and o_crd_overflow=1 until reset.
6. Assert i_rst during beat 1 of a 4-beat message. Expect valid=0 immediately, o_crd_count=CRD_MAX and o_msg_ready=1. After release, no further beats of the old message appear.
